uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Parametrised UART receiver, successor to the single-mode system UART RX. It uses 16x oversampling from a fractional-divider tick, majority-vote bit sampling, false-start rejection and configurable frame format. It reports framing, parity, break and overrun conditions, and buffers received characters in a small FIFO with a valid/ready output. It sits in the system block between the board RX pin and the host command/loader logic.

## Interface
- DIV_NUM, 25: bit period numerator; baud = clk / (DIV_NUM / DIV_DEN).
- DIV_DEN, 1: bit period denominator; requires DIV_NUM >= 16*DIV_DEN.
- DATA_BITS, 8: character width, legal 5..9.
- STOP_BITS, 1: stop bits checked, legal 1 or 2.
- FIFO_DEPTH, 4: FIFO entries, power of two, >= 2.
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- rx  in  1  asynchronous serial input, idle high.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none; sampled at start-bit confirmation.
- m_data  out  DATA_BITS  head-of-FIFO character.
- m_status  out  3  {break, frame_err, parity_err} for m_data.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accept; pop when m_valid && m_ready.
- overrun  out  1  one-cycle pulse when a completed character is dropped.
- busy  out  1  receiver not in IDLE.

## Operation
- rx passes a 2-FF synchroniser, reset to 1. All sampling uses the synchronised value.
- Tick generator: 16x-bit-rate accumulator acc (width clog2(DIV_NUM+16*DIV_DEN)).
  - Each clk, acc_next = acc + 16*DIV_DEN.
  - If acc_next >= DIV_NUM: tick = 1 and acc <= acc_next - DIV_NUM; else acc <= acc_next.
  - Free-running; cleared to 0 on the IDLE->START transition.
- Sample counter os (4 bits) advances on each tick. Each bit spans 16 ticks.
- Bit value = majority of the samples at os = 7, 8, 9.
- States:
  - IDLE: rx low -> START.
  - START: at os = 8, majority 0 -> DATA; majority 1 -> IDLE (false start, nothing written).
  - DATA: DATA_BITS bits, LSB first, shifted in at os = 8 of each bit. Then -> PARITY if parity is enabled, else -> STOP.
  - PARITY: sampled bit checked against XOR of data, with even/odd selected by parity_mode. parity_err = mismatch.
  - STOP: each of STOP_BITS bits sampled; any 0 sets frame_err.
    - At os = 8 of the last stop bit, write the entry and go to IDLE, or to BRK_WAIT on break.
    - Returning to IDLE half a bit early allows resync on back-to-back characters.
  - BRK_WAIT: entered when data = 0, parity bit (if any) = 0 and frame_err = 1. Waits for synchronised rx = 1, then -> IDLE.
- break = 1 implies frame_err = 1.
- FIFO write with FIFO full: entry dropped, overrun pulses, FIFO contents unchanged.
- Simultaneous push and pop when full: the pop is taken first, the push succeeds and no overrun occurs.

## Timing
- Reset values: m_valid 0, m_data 0, m_status 0, overrun 0, busy 0, state IDLE, acc 0, FIFO empty, synchroniser 1.
- rx to state machine latency: 2 clk (synchroniser).
- Entry written on the clk of the last stop-bit sample tick. m_valid rises on the next clk (first-word fall-through).
- Pop takes effect at the clk edge where m_valid && m_ready. The next entry is visible the following cycle.
- Reset mid-frame aborts asynchronously. The partial character is discarded and the FIFO is emptied.
- overrun pulse is coincident with the dropped write cycle.

## Configuration
- Macro: UART_RX_OS_PARITY_EN.
- Defined: PARITY state present; parity_mode honoured; parity_err reported.
- Undefined: no parity bit is expected and parity_mode is ignored.
  - m_status[0] is tied to 0.
  - The break test uses data and stop bits only.
- Ports are identical in both builds.

## Structure
- Package uart_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - parity_mode localparams: PAR_NONE, PAR_EVEN, PAR_ODD.
  - status bit index constants.
  - OVS = 16.
- Sub-module uart_rx_fifo: synchronous FWFT FIFO of width DATA_BITS+3 and depth FIFO_DEPTH. It exposes push/full and pop/empty. The receiver core stays in uart_rx_os.

## Test plan
- DIV_NUM=434, DIV_DEN=1, 8N1, send 0x55 -> m_data 0x55, m_status 000, exactly one entry.
- DIV_NUM=868, DIV_DEN=3 (fractional), send 0xA3, 0x00, 0xFF back-to-back -> three entries in order, status 000.
- With the macro defined, parity_mode even, send 0x07 with parity bit 0 -> m_data 0x07, status 001. With parity bit 1 -> status 000.
- 80-clk low glitch on rx (less than half a bit at DIV_NUM=434) -> no entry, busy returns to 0.
- rx held low for 2 character times, then high -> one entry, data 0x00, status 110. No further entry until rx idles and a new start bit arrives.
- FIFO_DEPTH=4 with m_ready=0, send 5 characters -> 4 entries retained, overrun pulses once on the 5th.
- Same overflow with m_ready=1 asserted on the 5th write cycle -> no overrun, 4 entries retained.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BRK_WAIT
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Bit positions inside the 3-bit status word {break, frame_err, parity_err}.
  localparam int ST_PAR = 0;
  localparam int ST_FRM = 1;
  localparam int ST_BRK = 2;
  localparam int ST_W   = 3;

  localparam int OVS = 16;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO for received characters. A push while full is
// accepted only when a pop happens in the same cycle (the pop is taken first).
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with majority vote, break/framing/overrun
// reporting and an output FIFO. Parity support is built with UART_RX_OS_PARITY_EN.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DIV_NUM    = 25,
  parameter int DIV_DEN    = 1,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx,
  input  logic [1:0]           parity_mode,
  output logic [DATA_BITS-1:0] m_data,
  output logic [2:0]           m_status,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  output logic                 busy
);

`ifdef UART_RX_OS_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  localparam int ACC_W = $clog2(DIV_NUM + OVS * DIV_DEN);
  localparam int ENT_W = DATA_BITS + ST_W;

  logic                 rx_s1_q, rx_s2_q;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [31:0]          acc_sum;
  logic                 tick;
  logic [3:0]           os_q, os_d;
  logic [1:0]           vote_q, vote_d;
  state_e               state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [1:0]           pmode_q, pmode_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 smp_tick, smp_bit, par_en, start_det;
  logic                 fe_now, brk_now;
  logic [ST_W-1:0]      st_now;
  logic                 push, fifo_full, fifo_empty;
  logic [ENT_W-1:0]     push_data, head;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // The bit decision is taken on the os=9 tick, once all three votes exist.
  assign smp_tick  = tick && (os_q == 4'd9);
  assign smp_bit   = maj3(vote_q[1], vote_q[0], rx_s2_q);
  assign par_en    = PAR_BUILD && ((pmode_q == PAR_EVEN) || (pmode_q == PAR_ODD));
  assign start_det = (state_q == IDLE) && !rx_s2_q;

  assign fe_now  = frm_err_q | ~smp_bit;
  assign brk_now = (shreg_q == '0) && (!par_en || !par_bit_q) && fe_now;

  always_comb begin
    st_now         = '0;
    st_now[ST_BRK] = brk_now;
    st_now[ST_FRM] = fe_now;
    st_now[ST_PAR] = PAR_BUILD ? par_err_q : 1'b0;
  end
  assign push_data = {st_now, shreg_q};

  always_comb begin
    acc_sum = 32'(acc_q) + 32'(OVS * DIV_DEN);
    tick    = (acc_sum >= 32'(DIV_NUM));
    acc_d   = tick ? ACC_W'(acc_sum - 32'(DIV_NUM)) : ACC_W'(acc_sum);
  end

  always_comb begin
    state_d   = state_q;
    os_d      = os_q;
    vote_d    = vote_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    pmode_d   = pmode_q;
    par_bit_d = par_bit_q;
    par_err_d = par_err_q;
    frm_err_d = frm_err_q;
    push      = 1'b0;
    if (tick) begin
      os_d   = os_q + 4'd1;
      vote_d = {vote_q[0], rx_s2_q};
    end
    case (state_q)
      IDLE: begin
        if (!rx_s2_q) begin
          state_d = START;
          os_d    = '0;
        end
      end
      START: begin
        if (smp_tick) begin
          if (!smp_bit) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            pmode_d   = parity_mode;
            par_bit_d = 1'b0;
            par_err_d = 1'b0;
            frm_err_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (smp_tick) begin
          shreg_d   = {smp_bit, shreg_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en ? PARITY : STOP;
          end
        end
      end
`ifdef UART_RX_OS_PARITY_EN
      PARITY: begin
        if (smp_tick) begin
          par_bit_d = smp_bit;
          par_err_d = (smp_bit ^ (^shreg_q)) != (pmode_q == PAR_ODD);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (smp_tick) begin
          frm_err_d = fe_now;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            push    = 1'b1;
            state_d = brk_now ? BRK_WAIT : IDLE;
          end
        end
      end
      BRK_WAIT: begin
        if (rx_s2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      acc_q     <= '0;
      os_q      <= '0;
      vote_q    <= 2'b11;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      pmode_q   <= PAR_NONE;
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      acc_q     <= start_det ? '0 : acc_d;
      os_q      <= os_d;
      vote_q    <= vote_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      pmode_q   <= pmode_d;
      par_bit_q <= par_bit_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  uart_rx_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_data),
    .full      (fifo_full),
    .pop       (m_ready),
    .pop_data  (head),
    .empty     (fifo_empty)
  );

  // A full FIFO always has a head, so m_ready alone decides whether it pops.
  assign overrun  = push && fifo_full && !m_ready;
  assign m_valid  = !fifo_empty;
  assign m_data   = fifo_empty ? '0 : head[DATA_BITS-1:0];
  assign m_status = fifo_empty ? '0 : head[ENT_W-1:DATA_BITS];
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: table vectors, hand sequences and randomized frames
// checked against a frame-level reference model.
module tb_uart_rx_os;

  localparam int DIV_NUM    = 434;
  localparam int DIV_DEN    = 4;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;
  localparam int FIFO_DEPTH = 4;

`ifdef UART_RX_OS_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic       m_ready = 1'b0;
  logic [1:0] parity_mode = 2'b00;
  logic [7:0] m_data;
  logic [2:0] m_status;
  logic       m_valid, overrun, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int ovr_cnt = 0;
  int frac    = 0;

  typedef struct {
    logic [7:0] d;
    logic [1:0] mode;
    bit         pb;
    bit         sb;
    logic [7:0] ed;
    logic [2:0] es;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] st;
  } exp_t;

  vec_t vecs[$];
  exp_t expq[$];

  always #5 clk = ~clk;

  uart_rx_os #(
    .DIV_NUM   (DIV_NUM),
    .DIV_DEN   (DIV_DEN),
    .DATA_BITS (DATA_BITS),
    .STOP_BITS (STOP_BITS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx         (rx),
    .parity_mode(parity_mode),
    .m_data     (m_data),
    .m_status   (m_status),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .overrun    (overrun),
    .busy       (busy)
  );

  always @(negedge clk) begin
    #2;
    if (overrun) ovr_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit par_used(input logic [1:0] mode);
    return PAR_BUILD && (mode == 2'b01 || mode == 2'b10);
  endfunction

  // Reference: status of one frame from its line-level contents.
  function automatic logic [2:0] model_status(input logic [7:0] d, input logic [1:0] mode,
                                              input bit pb, input bit sb);
    bit has_par, pe, fe, brk;
    int ones;
    has_par = par_used(mode);
    ones    = $countones(d) + (pb ? 1 : 0);
    pe      = has_par && ((mode == 2'b01) ? (ones % 2 == 1) : (ones % 2 == 0));
    fe      = !sb;
    brk     = (d == 8'h00) && !(has_par && pb) && fe;
    return {brk, fe, pe};
  endfunction

  task automatic wait_bits(input int n);
    for (int i = 0; i < n; i++) begin
      int c;
      frac += DIV_NUM;
      c = frac / DIV_DEN;
      frac -= c * DIV_DEN;
      repeat (c) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode, input bit pb, input bit sb);
    parity_mode = mode;
    rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx = d[i];
      wait_bits(1);
    end
    if (par_used(mode)) begin
      rx = pb;
      wait_bits(1);
    end
    for (int i = 0; i < STOP_BITS; i++) begin
      rx = sb;
      wait_bits(1);
    end
    rx = 1'b1;
  endtask

  task automatic pop_expect(input string name, input logic [7:0] ed, input logic [2:0] es);
    int t = 0;
    while (!m_valid && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (!m_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_valid: got m_valid=0 after %0d cycles, want 1", name, t);
    end else begin
      check({name, "_data"}, 32'(m_data), 32'(ed));
      check({name, "_st"}, 32'(m_status), 32'(es));
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
  endtask

  initial begin
    int base;
    bit seen;

    vecs.push_back('{8'h55, 2'b00, 1'b0, 1'b1, 8'h55, 3'b000});
    vecs.push_back('{8'h3C, 2'b00, 1'b0, 1'b0, 8'h3C, 3'b010});
    vecs.push_back('{8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 3'b110});
    vecs.push_back('{8'hFF, 2'b00, 1'b0, 1'b1, 8'hFF, 3'b000});
    vecs.push_back('{8'h80, 2'b11, 1'b0, 1'b1, 8'h80, 3'b000});
`ifdef UART_RX_OS_PARITY_EN
    vecs.push_back('{8'h07, 2'b01, 1'b0, 1'b1, 8'h07, 3'b001});
    vecs.push_back('{8'h07, 2'b01, 1'b1, 1'b1, 8'h07, 3'b000});
    vecs.push_back('{8'h07, 2'b10, 1'b0, 1'b1, 8'h07, 3'b000});
    vecs.push_back('{8'h00, 2'b10, 1'b0, 1'b0, 8'h00, 3'b111});
    vecs.push_back('{8'h00, 2'b01, 1'b1, 1'b0, 8'h00, 3'b011});
`else
    vecs.push_back('{8'h07, 2'b01, 1'b0, 1'b1, 8'h07, 3'b000});
    vecs.push_back('{8'h00, 2'b10, 1'b0, 1'b0, 8'h00, 3'b110});
`endif

    repeat (3) @(negedge clk);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_data", 32'(m_data), 0);
    check("rst_status", 32'(m_status), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_busy", 32'(busy), 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      send_frame(vecs[i].d, vecs[i].mode, vecs[i].pb, vecs[i].sb);
      wait_bits(2);
      pop_expect($sformatf("vec%0d", i), vecs[i].ed, vecs[i].es);
      check($sformatf("vec%0d_single", i), 32'(m_valid), 0);
    end

    send_frame(8'hA3, 2'b00, 1'b0, 1'b1);
    send_frame(8'h00, 2'b00, 1'b0, 1'b1);
    send_frame(8'hFF, 2'b00, 1'b0, 1'b1);
    wait_bits(2);
    pop_expect("b2b0", 8'hA3, 3'b000);
    pop_expect("b2b1", 8'h00, 3'b000);
    pop_expect("b2b2", 8'hFF, 3'b000);
    check("b2b_count", 32'(m_valid), 0);

    rx = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_busy_hi", 32'(busy), 1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    wait_bits(3);
    check("glitch_busy_lo", 32'(busy), 0);
    check("glitch_noentry", 32'(m_valid), 0);

    rx = 1'b0;
    wait_bits(20);
    rx = 1'b1;
    wait_bits(3);
    pop_expect("brk", 8'h00, 3'b110);
    check("brk_single", 32'(m_valid), 0);
    check("brk_idle", 32'(busy), 0);
    send_frame(8'h5A, 2'b00, 1'b0, 1'b1);
    wait_bits(2);
    pop_expect("post_brk", 8'h5A, 3'b000);

    base = ovr_cnt;
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h11 + 8'(i), 2'b00, 1'b0, 1'b1);
      wait_bits(2);
    end
    check("ovf1_pulses", 32'(ovr_cnt - base), 1);
    for (int i = 0; i < 4; i++) pop_expect($sformatf("ovf1_e%0d", i), 8'h11 + 8'(i), 3'b000);
    check("ovf1_count", 32'(m_valid), 0);

    base = ovr_cnt;
    for (int i = 0; i < 4; i++) begin
      send_frame(8'h21 + 8'(i), 2'b00, 1'b0, 1'b1);
      wait_bits(2);
    end
    seen = 1'b0;
    fork
      send_frame(8'h25, 2'b00, 1'b0, 1'b1);
      begin
        for (int k = 0; k < 2000 && !seen; k++) begin
          @(negedge clk);
          if (overrun) begin
            m_ready = 1'b1;
            seen = 1'b1;
          end
        end
        if (seen) begin
          @(negedge clk);
          m_ready = 1'b0;
        end
      end
    join
    wait_bits(2);
    check("ovf2_write_seen", 32'(seen), 1);
    check("ovf2_pulses", 32'(ovr_cnt - base), 0);
    for (int i = 0; i < 4; i++) pop_expect($sformatf("ovf2_e%0d", i), 8'h22 + 8'(i), 3'b000);
    check("ovf2_count", 32'(m_valid), 0);

    send_frame(8'h42, 2'b00, 1'b0, 1'b1);
    wait_bits(2);
    rx = 1'b0;
    wait_bits(4);
    resetn = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_valid", 32'(m_valid), 0);
    check("mrst_data", 32'(m_data), 0);
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    wait_bits(2);
    check("mrst_idle", 32'(busy), 0);
    send_frame(8'h99, 2'b00, 1'b0, 1'b1);
    wait_bits(2);
    pop_expect("mrst_after", 8'h99, 3'b000);

    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 3; i++) begin
        logic [7:0] d;
        logic [1:0] mode;
        bit pb, sb;
        d    = 8'($urandom);
        mode = 2'($urandom);
        pb   = 1'($urandom);
        sb   = ($urandom_range(0, 3) != 0);
        send_frame(d, mode, pb, sb);
        wait_bits($urandom_range(2, 3));
        expq.push_back('{d, model_status(d, mode, pb, sb)});
      end
      while (expq.size() > 0) begin
        exp_t e;
        e = expq.pop_front();
        pop_expect($sformatf("rnd%0d", b), e.d, e.st);
      end
      check($sformatf("rnd%0d_count", b), 32'(m_valid), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
